traffic_sys: RTL and testbench

TRAFFIC_SYS -- requirements
Module: traffic_sys

---
 rtl/traffic_sys.sv | 82 ++++++++
 tb/tb_traffic_sys.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/traffic_sys.sv
// ============================================================================
//  Module      : traffic_sys
//  Description : Four-way fixed-rotation traffic light controller (Moore FSM).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_sys #(
  parameter int GREEN_CYCLES  = 5,
  parameter int YELLOW_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] north_light,
  output logic [2:0] west_light,
  output logic [2:0] south_light,
  output logic [2:0] east_light
);

  // State = {illegal, direction[1:0], yellow}; the rotation order is a plain increment.
  localparam logic [3:0] N_G = 4'd0;
  localparam logic [3:0] N_Y = 4'd1;
  localparam logic [3:0] W_G = 4'd2;
  localparam logic [3:0] W_Y = 4'd3;
  localparam logic [3:0] S_G = 4'd4;
  localparam logic [3:0] S_Y = 4'd5;
  localparam logic [3:0] E_G = 4'd6;
  localparam logic [3:0] E_Y = 4'd7;

  localparam logic [7:0] c_GREEN_LAST  = 8'(GREEN_CYCLES - 1);
  localparam logic [7:0] c_YELLOW_LAST = 8'(YELLOW_CYCLES - 1);

  localparam logic [2:0] c_LAMP_G = 3'b001;
  localparam logic [2:0] c_LAMP_Y = 3'b010;
  localparam logic [2:0] c_LAMP_R = 3'b100;

  logic [3:0] state_q, state_d;
  logic [7:0] cnt_q,   cnt_d;
  logic       phase_last;
  logic [2:0] lamp [4];

  assign phase_last = state_q[0] ? (cnt_q == c_YELLOW_LAST) : (cnt_q == c_GREEN_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    if (state_q[3]) begin
      state_d = N_G;
      cnt_d   = 8'd0;
    end else if (phase_last) begin
      // E_Y wraps to N_G through the 3-bit increment.
      state_d = {1'b0, state_q[2:0] + 3'd1};
      cnt_d   = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= N_G;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // An unencoded state shows north green, matching the state it falls into next edge.
  for (genvar d = 0; d < 4; d++) begin : g_dir
    logic active;
    assign active  = state_q[3] ? (d == 0) : (state_q[2:1] == 2'(d));
    assign lamp[d] = !active ? c_LAMP_R :
                     (state_q[0] && !state_q[3]) ? c_LAMP_Y : c_LAMP_G;
  end

  assign north_light = lamp[0];
  assign west_light  = lamp[1];
  assign south_light = lamp[2];
  assign east_light  = lamp[3];

endmodule

`default_nettype wire

// File: tb/tb_traffic_sys.sv
// ============================================================================
//  Module      : tb_traffic_sys
//  Description : Scoreboard bench for traffic_sys at default and 1/1 timing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_sys;

  logic       clk;
  logic       reset;
  logic [2:0] n_a, w_a, s_a, e_a;
  logic [2:0] n_b, w_b, s_b, e_b;

  int errors = 0;
  int checks = 0;

  logic [11:0] q_a[$];
  logic [11:0] q_b[$];

  int a_idx = 0, a_cnt = 0;
  int b_idx = 0, b_cnt = 0;

  traffic_sys u_dut_a (
    .clk(clk), .reset(reset),
    .north_light(n_a), .west_light(w_a), .south_light(s_a), .east_light(e_a)
  );

  traffic_sys #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .north_light(n_b), .west_light(w_b), .south_light(s_b), .east_light(e_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {north, west, south, east} for state index 0..7 (N_G .. E_Y).
  function automatic logic [11:0] exp_lamps(input int idx);
    logic [2:0] l [4];
    for (int d = 0; d < 4; d++) l[d] = 3'b100;
    l[idx / 2] = (idx % 2 == 1) ? 3'b010 : 3'b001;
    return {l[0], l[1], l[2], l[3]};
  endfunction

  task automatic advance(inout int idx, inout int cnt, input int g, input int y, input logic rst);
    int last;
    last = (idx % 2 == 1) ? y - 1 : g - 1;
    if (rst) begin
      idx = 0; cnt = 0;
    end else if (cnt == last) begin
      idx = (idx + 1) % 8; cnt = 0;
    end else begin
      cnt = cnt + 1;
    end
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_one_lit(input string tag, input logic [11:0] obs);
    int lit;
    lit = 0;
    for (int d = 0; d < 4; d++) if (obs[d*3 +: 3] != 3'b100) lit++;
    checks++;
    assert (lit === 1) else begin
      errors++;
      $error("FAIL %s non_red_count observed=%0d expected=1", tag, lit);
    end
  endtask

  // Drive reset, push model predictions, clock once, then pop and compare.
  task automatic tick(input logic rst);
    reset = rst;
    advance(a_idx, a_cnt, 5, 2, rst);
    advance(b_idx, b_cnt, 1, 1, rst);
    q_a.push_back(exp_lamps(a_idx));
    q_b.push_back(exp_lamps(b_idx));
    @(posedge clk);
    #1;
    check("dflt_lamps", {n_a, w_a, s_a, e_a}, q_a.pop_front());
    check("fast_lamps", {n_b, w_b, s_b, e_b}, q_b.pop_front());
    check_one_lit("dflt_one_lit", {n_a, w_a, s_a, e_a});
  endtask

  initial begin
    int guard;
    reset = 1'b1;

    // Reset edge at 5 ns, released for the edge at 15 ns.
    tick(1'b1);
    check("reset_north", {9'd0, n_a}, {9'd0, 3'b001});
    check("reset_others", {3'd0, w_a, s_a, e_a}, {3'd0, 9'b100_100_100});

    // Edges 15..55 ns: north turns yellow at the 55 ns edge.
    for (int i = 0; i < 5; i++) tick(1'b0);
    check("north_yellow_60ns", {9'd0, n_a}, {9'd0, 3'b010});

    // Edge 75 ns: west goes green.
    for (int i = 0; i < 2; i++) tick(1'b0);
    check("west_green_75ns", {n_a, w_a}, {3'b100, 3'b001});

    // Complete the 28-cycle rotation back to N_G.
    for (int i = 0; i < 21; i++) tick(1'b0);
    check("rotation_28", {n_a, w_a, s_a, e_a}, 12'b001_100_100_100);

    // Advance to S_Y, then pulse reset for one cycle.
    guard = 0;
    while (a_idx != 5 && guard < 64) begin
      tick(1'b0);
      guard++;
    end
    check("reach_s_y", {9'd0, s_a}, {9'd0, 3'b010});
    tick(1'b1);
    check("mid_reset_north", {n_a, s_a}, {3'b001, 3'b100});
    for (int i = 0; i < 4; i++) tick(1'b0);
    check("full_green_after_reset", {9'd0, n_a}, {9'd0, 3'b001});
    tick(1'b0);
    check("yellow_after_full_green", {9'd0, n_a}, {9'd0, 3'b010});

    // Reset held high keeps reset outputs.
    for (int i = 0; i < 3; i++) tick(1'b1);
    check("reset_hold", {n_a, w_a, s_a, e_a}, 12'b001_100_100_100);

    for (int i = 0; i < 40; i++) tick(1'b0);

    checks++;
    assert (q_a.size() === 0 && q_b.size() === 0) else begin
      errors++;
      $error("FAIL queue_drain observed=%0d expected=0", q_a.size() + q_b.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
